imem_stream_loader: RTL and testbench

- Boot/load controller for pipe_MIPS20.
- Accepts a stream of 32-bit instruction words over a valid/ready interface and writes them into instruction memory from address 0.
- Then releases the core to run, and reports completion when the core's halted flag rises (HLT, FC000000).
- Hardware replacement for bench-side direct writes to Mem and waiting on halted_out.

---
 rtl/imem_stream_loader_if.sv | 23 ++
 rtl/imem_stream_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_stream_loader.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_stream_loader_if.sv
// Stream-in and instruction-memory write bundle for the boot loader.
// The master view belongs to the loader: it consumes the word stream and drives the write port.
interface imem_stream_loader_if #(
  parameter int ADDR_W = 10
);
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_last;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  s_valid, s_data, s_last,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data, s_last,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Boot/load controller for pipe_MIPS20: streams a program into instruction memory from
// address 0, releases the core, and reports a normal halt, a memory overflow or a run timeout.
module imem_stream_loader #(
  parameter int ADDR_W     = 10,
  parameter int CYC_W      = 20,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                start,
  imem_stream_loader_if.master bus,
  output logic                cpu_run,
  input  logic                halted_in,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     word_count,
  output logic [CYC_W-1:0]    run_cycles
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [CYC_W-1:0]  CYC_LIMIT  = CYC_W'(MAX_CYCLES);
  localparam logic [CYC_W-1:0]  CYC_SAT    = '1;
  localparam logic [1:0]        ERR_OVFL   = 2'd1;
  localparam logic [1:0]        ERR_TMOUT  = 2'd2;

  state_t            state_q, state_d;
  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [CYC_W-1:0]  run_cycles_q, run_cycles_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              accept;
  logic [CYC_W-1:0]  run_next;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ptr_q        <= '0;
      word_count_q <= '0;
      run_cycles_q <= '0;
      cpu_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      run_cycles_q <= run_cycles_d;
      cpu_run_q    <= cpu_run_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_ready_d    = s_ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    run_cycles_d = run_cycles_q;
    cpu_run_d    = cpu_run_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    accept       = 1'b0;
    run_next     = run_cycles_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d      = LOAD;
          s_ready_d    = 1'b1;
          ptr_d        = '0;
          word_count_d = '0;
          run_cycles_d = '0;
          cpu_run_d    = 1'b0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          err_code_d   = '0;
        end
      end
      LOAD: begin
        accept = bus.s_valid & s_ready_q;
        if (accept) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = ptr_q;
          mem_wdata_d  = bus.s_data;
          ptr_d        = ptr_q + 1'b1;
          word_count_d = word_count_q + 1'b1;
          if (bus.s_last) begin
            state_d   = RUN;
            s_ready_d = 1'b0;
          end else if (ptr_q == LAST_ADDR) begin
            state_d    = ERR;
            s_ready_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_OVFL;
          end
        end
      end
      RUN: begin
        // The first RUN cycle overlaps the final write, so the core is released one cycle later.
        if (!cpu_run_q) begin
          cpu_run_d = 1'b1;
        end else begin
          if (run_cycles_q != CYC_SAT) begin
            run_next = run_cycles_q + 1'b1;
          end
          run_cycles_d = run_next;
          if (halted_in) begin
            state_d   = DONE;
            cpu_run_d = 1'b0;
            done_d    = 1'b1;
          end else if (run_next >= CYC_LIMIT) begin
            state_d    = ERR;
            cpu_run_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_TMOUT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LOAD) || (state_d == RUN);
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_run       = cpu_run_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign word_count    = word_count_q;
  assign run_cycles    = run_cycles_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: random programs and stream gaps are checked
// against a write log and expectations derived from the load/run rules.
module tb_imem_stream_loader;

  localparam int AW    = 4;
  localparam int CW    = 8;
  localparam int MAXC  = 50;
  localparam int DEPTH = 1 << AW;

  logic          clk1;
  logic          rst_n;
  logic          start;
  logic          halted_in;
  logic          cpu_run;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;
  logic [CW-1:0] run_cycles;

  imem_stream_loader_if #(.ADDR_W(AW)) bus ();

  imem_stream_loader #(.ADDR_W(AW), .CYC_W(CW), .MAX_CYCLES(MAXC)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .cpu_run    (cpu_run),
    .halted_in  (halted_in),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .word_count (word_count),
    .run_cycles (run_cycles)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0]   prog [0:DEPTH];
  logic [AW-1:0] wr_addr [$];
  logic [31:0]   wr_data [$];
  int            wr_cyc  [$];
  int            cyc = 0;
  int            run_first_cyc = -1;
  int            run_hi_cnt = 0;
  bit            run_seen = 0;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Write/run log sampled just after each rising edge: the memory image the core would see.
  initial begin
    forever begin
      @(posedge clk1);
      #1;
      cyc++;
      if (rst_n) begin
        if (bus.mem_we) begin
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_wdata);
          wr_cyc.push_back(cyc);
        end
        if (cpu_run) begin
          if (!run_seen) run_first_cyc = cyc;
          run_seen = 1;
          run_hi_cnt++;
        end
      end
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    run_first_cyc = -1;
    run_hi_cnt    = 0;
    run_seen      = 0;
  endtask

  task automatic load_mul();
    logic [31:0] nop;
    nop = 32'h0CE77800;
    for (int i = 0; i < 13; i++) prog[i] = nop;
    prog[0]  = 32'h2801000A;
    prog[4]  = 32'h28020005;
    prog[8]  = 32'h14221800;
    prog[12] = 32'hFC000000;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) prog[i] = $urandom;
  endtask

  task automatic apply_reset();
    @(negedge clk1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    start       = 1'b0;
    halted_in   = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic start_session();
    halted_in = 1'b0;
    start     = 1'b1;
    @(negedge clk1);
    start = 1'b0;
  endtask

  // gap_mode 0: back-to-back, 1: two idle cycles between words, 2: random 0..3 idle cycles.
  task automatic stream_words(input int first, input int n, input bit last_on_final, input int gap_mode);
    int w;
    for (int i = first; i < first + n; i++) begin
      if (i != first) begin
        if (gap_mode == 1) repeat (2) @(negedge clk1);
        else if (gap_mode == 2) repeat ($urandom_range(0, 3)) @(negedge clk1);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = prog[i];
      bus.s_last  = last_on_final && (i == first + n - 1);
      w = 0;
      while (!bus.s_ready && w < 20) begin
        @(negedge clk1);
        w++;
      end
      if (!bus.s_ready) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL stream_wait: word %0d never accepted, s_ready=%0b required 1", i, bus.s_ready);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        return;
      end
      @(negedge clk1);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
  endtask

  // Core stand-in: raises halted after halt_after released cycles (0 = never halts).
  task automatic run_core(input int halt_after);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk1);
      if (cpu_run) cnt++;
      if (halt_after > 0 && cnt == halt_after) halted_in = 1'b1;
      if (!busy) return;
    end
    vectors++;
    miscompares++;
    $display("[TB] FAIL run_wait: busy=%0b after 300 cycles, required 0", busy);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    halted_in   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    #22;
    vectors++;
    if ({cpu_run, busy, done, error, err_code} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got %b required 000000", {cpu_run, busy, done, error, err_code});
    end
    vectors++;
    if (word_count !== '0 || run_cycles !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_counts: word_count=%0d run_cycles=%0d required 0/0", word_count, run_cycles);
    end
    vectors++;
    if ({bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: s_ready=%0b mem_we=%0b addr=%0h wdata=%0h required all 0",
               bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
  endtask

  task automatic test_session(input string name, input int n, input int gap_mode, input int halt_after);
    int   exp_rc;
    bit   exp_done;
    int   last_cyc;
    logic [3:0] exp_status;
    exp_done   = (halt_after >= 1) && (halt_after <= MAXC);
    exp_rc     = exp_done ? halt_after : MAXC;
    exp_status = exp_done ? 4'b1000 : 4'b0110;
    clear_log();
    start_session();
    stream_words(0, n, 1'b1, gap_mode);
    run_core(halt_after);

    vectors++;
    if (wr_addr.size() != n) begin
      miscompares++;
      $display("[TB] FAIL %s_write_count: got %0d required %0d", name, wr_addr.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (i >= wr_addr.size()) begin
        miscompares++;
        $display("[TB] FAIL %s_write[%0d]: missing, required addr %0d data %h", name, i, i, prog[i]);
      end else if (wr_addr[i] !== AW'(i) || wr_data[i] !== prog[i]) begin
        miscompares++;
        $display("[TB] FAIL %s_write[%0d]: got addr %0d data %h required addr %0d data %h",
                 name, i, wr_addr[i], wr_data[i], i, prog[i]);
      end
    end
    last_cyc = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -100;
    vectors++;
    if (!run_seen || run_first_cyc != last_cyc + 1) begin
      miscompares++;
      $display("[TB] FAIL %s_release: cpu_run first at %0d required %0d", name, run_first_cyc, last_cyc + 1);
    end
    vectors++;
    if (run_hi_cnt != exp_rc || run_cycles !== CW'(exp_rc)) begin
      miscompares++;
      $display("[TB] FAIL %s_run_cycles: cpu_run high %0d, run_cycles=%0d required %0d",
               name, run_hi_cnt, run_cycles, exp_rc);
    end
    vectors++;
    if ({done, error, err_code} !== exp_status) begin
      miscompares++;
      $display("[TB] FAIL %s_status: done/error/err_code got %b required %b", name, {done, error, err_code}, exp_status);
    end
    vectors++;
    if (word_count !== (AW+1)'(n) || busy !== 1'b0 || cpu_run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_final: word_count=%0d busy=%0b cpu_run=%0b required %0d/0/0",
               name, word_count, busy, cpu_run, n);
    end
  endtask

  task automatic test_overflow();
    load_random(DEPTH + 1);
    clear_log();
    start_session();
    stream_words(0, DEPTH, 1'b0, 2);
    bus.s_valid = 1'b1;
    bus.s_data  = prog[DEPTH];
    repeat (5) @(negedge clk1);
    bus.s_valid = 1'b0;
    vectors++;
    if ({error, err_code, bus.s_ready, busy} !== 5'b10100) begin
      miscompares++;
      $display("[TB] FAIL ovfl_status: error/err_code/s_ready/busy got %b required 10100",
               {error, err_code, bus.s_ready, busy});
    end
    vectors++;
    if (wr_addr.size() != DEPTH || word_count !== (AW+1)'(DEPTH)) begin
      miscompares++;
      $display("[TB] FAIL ovfl_count: writes=%0d word_count=%0d required %0d", wr_addr.size(), word_count, DEPTH);
    end
    for (int i = 0; i < wr_addr.size() && i < DEPTH; i++) begin
      vectors++;
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== prog[i]) begin
        miscompares++;
        $display("[TB] FAIL ovfl_write[%0d]: got addr %0d data %h required addr %0d data %h",
                 i, wr_addr[i], wr_data[i], i, prog[i]);
      end
    end
    vectors++;
    if (run_seen) begin
      miscompares++;
      $display("[TB] FAIL ovfl_cpu_run: cpu_run seen %0b required 0", run_seen);
    end
  endtask

  task automatic test_start_with_valid();
    load_random(1);
    clear_log();
    start       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = prog[0];
    bus.s_last  = 1'b1;
    vectors++;
    if (bus.s_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL startvalid_ready_idle: got %0b required 0", bus.s_ready);
    end
    @(negedge clk1);
    start = 1'b0;
    vectors++;
    if (wr_addr.size() != 0 || bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL startvalid_first_load: writes=%0d s_ready=%0b required 0/1", wr_addr.size(), bus.s_ready);
    end
    @(negedge clk1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    run_core(2);
    vectors++;
    if (wr_addr.size() != 1 || wr_addr[0] !== '0 || wr_data[0] !== prog[0]) begin
      miscompares++;
      $display("[TB] FAIL startvalid_write: writes=%0d required 1 at addr 0 data %h", wr_addr.size(), prog[0]);
    end
    vectors++;
    if (done !== 1'b1 || word_count !== 5'd1 || run_cycles !== 8'd2) begin
      miscompares++;
      $display("[TB] FAIL startvalid_end: done=%0b word_count=%0d run_cycles=%0d required 1/1/2",
               done, word_count, run_cycles);
    end
  endtask

  task automatic test_reset_midload();
    load_mul();
    clear_log();
    start_session();
    stream_words(0, 5, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({cpu_run, busy, done, error, err_code, bus.s_ready, bus.mem_we} !== 8'b0 ||
        word_count !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL midload_reset: status=%b word_count=%0d addr=%0d wdata=%h required all 0",
               {cpu_run, busy, done, error, err_code, bus.s_ready, bus.mem_we}, word_count, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    test_session("reload", 13, 0, 9);
  endtask

  task automatic test_ignored_inputs();
    int k;
    load_mul();
    clear_log();
    start_session();
    stream_words(0, 4, 1'b0, 0);
    halted_in = 1'b1;
    repeat (3) @(negedge clk1);
    vectors++;
    if ({busy, bus.s_ready, done, cpu_run} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL ign_halt_in_load: busy/s_ready/done/cpu_run got %b required 1100",
               {busy, bus.s_ready, done, cpu_run});
    end
    halted_in = 1'b0;
    stream_words(4, 9, 1'b1, 0);
    k = 0;
    while (!cpu_run && k < 10) begin
      @(negedge clk1);
      k++;
    end
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    vectors++;
    if ({busy, cpu_run, done} !== 3'b110 || word_count !== 5'd13 || wr_addr.size() != 13) begin
      miscompares++;
      $display("[TB] FAIL ign_start_in_run: busy/cpu_run/done=%b word_count=%0d writes=%0d required 110/13/13",
               {busy, cpu_run, done}, word_count, wr_addr.size());
    end
    halted_in = 1'b1;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk1);
      k++;
    end
    vectors++;
    if ({done, error, busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL ign_done: done/error/busy got %b required 100", {done, error, busy});
    end
    start_session();
    vectors++;
    if ({done, busy, bus.s_ready} !== 3'b011 || word_count !== '0 || run_cycles !== '0) begin
      miscompares++;
      $display("[TB] FAIL ign_restart_clear: done/busy/s_ready=%b word_count=%0d run_cycles=%0d required 011/0/0",
               {done, busy, bus.s_ready}, word_count, run_cycles);
    end
    apply_reset();
  endtask

  task automatic test_random();
    int n;
    int h;
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, DEPTH);
      h = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, MAXC);
      load_random(n);
      test_session("random", n, 2, h);
    end
  endtask

  initial begin
    test_reset();
    load_mul();
    test_session("mul", 13, 0, 20);
    load_mul();
    test_session("gapped", 13, 1, 11);
    load_random(DEPTH);
    test_session("full_depth", DEPTH, 0, 5);
    load_random(6);
    test_session("timeout", 6, 2, 0);
    load_random(3);
    test_session("halt_at_limit", 3, 0, MAXC);
    test_overflow();
    test_start_with_valid();
    test_reset_midload();
    test_ignored_inputs();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
